mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter that shares one memory-device port (req/gnt/rvalid protocol, e.g. a `ram_2p` port or a `bus` host slot) between `NrHosts` requesters such as core instruction fetch and core data. It forwards one request per cycle with zero added latency. It records the granting host of every accepted transaction in an in-order response FIFO, and uses that record to steer each `dev_rvalid_i` back to its originator. It sits between the hosts and the device, and the device side is pin-compatible with a single bus host.

## Interface
- `NrHosts`, default 2: number of requesters, 2..8.
- `DataWidth`, default 32: data bus width.
- `AddressWidth`, default 32: address bus width.
- `MaxOutstanding`, default 2: response FIFO depth, i.e. the maximum number of accepted but unanswered transactions, 1..8.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `host_req_i` in 1 `[NrHosts]`: host request.
- `host_gnt_o` out 1 `[NrHosts]`: host grant.
- `host_addr_i` in AddressWidth `[NrHosts]`: host address.
- `host_we_i` in 1 `[NrHosts]`: host write enable.
- `host_be_i` in DataWidth/8 `[NrHosts]`: host byte enables.
- `host_wdata_i` in DataWidth `[NrHosts]`: host write data.
- `host_rvalid_o` out 1 `[NrHosts]`: response valid, asserted for the originating host only.
- `host_rdata_o` out DataWidth `[NrHosts]`: response data, `dev_rdata_i` broadcast to all hosts.
- `host_err_o` out 1 `[NrHosts]`: response error, asserted for the originating host only.
- `dev_req_o` out 1: device request.
- `dev_gnt_i` in 1: device grant.
- `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o` out: request fields of the selected host.
- `dev_rvalid_i` in 1: device response valid.
- `dev_rdata_i` in DataWidth: device response data.
- `dev_err_i` in 1: device response error.
- `unexp_rsp_o` out 1: sticky flag, set when `dev_rvalid_i` arrives while the FIFO is empty.

## Operation
- State:
  - `rr_ptr` (index of the highest-priority host),
  - `lock_q` / `lock_idx_q` (pending ungranted request),
  - response FIFO of host indices with `count` 0..MaxOutstanding,
  - `unexp_q`.
- Selection (combinational):
  - If `count == MaxOutstanding`, there is no winner.
  - Else if `lock_q` is set and `host_req_i[lock_idx_q]` is high, the winner is `lock_idx_q`.
  - Otherwise the winner is the first requesting host scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo NrHosts.
- Forwarding:
  - With a winner: `dev_req_o`=1, `dev_*` fields come from the winner, and `host_gnt_o[winner]`=`dev_gnt_i`. All other grants are 0.
  - With no winner: `dev_req_o`=0 and the `dev_*` fields are 0.
- Handshake (`dev_req_o & dev_gnt_i`):
  - push the winner index,
  - `rr_ptr` ← (winner+1) mod NrHosts,
  - `lock_q` ← 0.
- Stall (`dev_req_o & !dev_gnt_i`): `lock_q` ← 1, `lock_idx_q` ← winner. The request stays on the same host until granted.
- Locked host drops `host_req_i` before its grant (protocol violation): the lock is ignored that cycle and cleared, and normal round-robin applies.
- Response (`dev_rvalid_i`, FIFO non-empty):
  - pop the head,
  - `host_rvalid_o[head]`=1,
  - `host_err_o[head]`=`dev_err_i`,
  - all other `host_rvalid_o` and `host_err_o` are 0.
- Response with the FIFO empty: dropped, with no host rvalid. `unexp_q` ← 1 and stays set until reset. `count` stays 0.
- Simultaneous push and pop: `count` is unchanged and ordering is preserved.
- Full FIFO: no request is issued. A pop in the same cycle does not enable a grant until the next cycle, so there is no `dev_rvalid_i` → `dev_req_o` combinational path.
- Response data: `host_rdata_o[i]` = `dev_rdata_i` for all i, unregistered.

## Timing
- Request path is combinational, with 0 added cycles from `host_req_i` to `dev_req_o` and from `dev_gnt_i` to `host_gnt_o`.
- Response path is combinational, with 0 added cycles from `dev_rvalid_i` to `host_rvalid_o`.
- Reset values:
  - `rr_ptr`=0, `count`=0, `lock_q`=0, `unexp_q`=0,
  - all `host_gnt_o`, `host_rvalid_o`, `host_err_o` are 0,
  - `dev_req_o`=0 and the `dev_*` fields are 0,
  - `unexp_rsp_o`=0.
- Reset mid-transaction flushes the FIFO. Responses arriving after reset are treated as unexpected.
- Throughput with a 1-cycle-latency device and `dev_gnt_i` tied high:
  - MaxOutstanding ≥ 2 gives 1 transaction per cycle.
  - MaxOutstanding = 1 gives 1 transaction per 2 cycles.
- Fairness: with all hosts requesting continuously, each host is granted once per NrHosts grants.

## Test plan
- **Single host:** NrHosts=2, `dev_gnt_i`=1, 1-cycle device, host 0 reads 0x100000 → `dev_req_o` same cycle, `host_rvalid_o[0]`=1 next cycle with data, `host_rvalid_o[1]`=0.
- **Contention:** both hosts request continuously for 8 cycles → grant sequence 0,1,0,1,0,1,0,1 and responses steered in matching order.
- **Device stall:** `dev_gnt_i`=0 for 3 cycles while host 0 is winner and host 1 also requests → `dev_addr_o` stays at host 0's address, host 0 is granted in cycle 4, and host 1 is granted next.
- **Full FIFO:** MaxOutstanding=2, device withholds `dev_rvalid_i` → after 2 grants `dev_req_o`=0. The first rvalid pops, and a new grant is possible only the following cycle.
- **Error routing:** host 1 write with `dev_err_i`=1 on its response → `host_err_o[1]`=1, `host_err_o[0]`=0, `count` returns to 0.
- **Unexpected response and reset:** `dev_rvalid_i` pulsed with the FIFO empty → no host rvalid and `unexp_rsp_o`=1 held. Asserting `rst_ni`=0 mid-stream clears it, sets `count`=0, and drops all outputs low immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between NrHosts requesters.
// An in-order FIFO of granted host indices steers each device response back to its originator.
module mem_port_arbiter #(
   parameter int NrHosts        = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NrHosts-1:0]      host_req_i,
   output logic [NrHosts-1:0]      host_gnt_o,
   input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
   input  logic [NrHosts-1:0]      host_we_i,
   input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
   input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
   output logic [NrHosts-1:0]      host_rvalid_o,
   output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
   output logic [NrHosts-1:0]      host_err_o,
   output logic                    dev_req_o,
   input  logic                    dev_gnt_i,
   output logic [AddressWidth-1:0] dev_addr_o,
   output logic                    dev_we_o,
   output logic [DataWidth/8-1:0]  dev_be_o,
   output logic [DataWidth-1:0]    dev_wdata_o,
   input  logic                    dev_rvalid_i,
   input  logic [DataWidth-1:0]    dev_rdata_i,
   input  logic                    dev_err_i,
   output logic                    unexp_rsp_o
);

   localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [PtrW-1:0] ptr_t;

   function automatic idx_t idx_inc(input idx_t i);
      return (i == idx_t'(NrHosts - 1)) ? '0 : i + idx_t'(1);
   endfunction

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   idx_t            rr_ptr_q;
   logic            lock_q;
   idx_t            lock_idx_q;
   idx_t            fifo_q [MaxOutstanding];
   ptr_t            rd_ptr_q;
   ptr_t            wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic            unexp_q;

   logic win_found;
   idx_t win_idx;
   logic fifo_full;
   logic fifo_empty;
   logic lock_hit;
   logic handshake;
   logic stall;
   logic push;
   logic pop;
   idx_t head;
   int   cand;

   // Both sides use req/gnt: a request is accepted in a cycle where req and gnt are
   // both high, and a request left ungranted must be held until it is granted.
   // Responses (rvalid) carry no back-pressure and return in request order.
   assign fifo_full  = (count_q == CntW'(MaxOutstanding));
   assign fifo_empty = (count_q == '0);
   assign lock_hit   = lock_q && host_req_i[lock_idx_q];
   assign head       = fifo_q[rd_ptr_q];

   // Winner selection; fullness uses the registered count so rvalid never reaches dev_req_o.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      if (rst_ni && !fifo_full) begin
         if (lock_hit) begin
            win_found = 1'b1;
            win_idx   = lock_idx_q;
         end else begin
            for (int k = 0; k < NrHosts; k++) begin
               cand = int'(rr_ptr_q) + k;
               if (cand >= NrHosts) cand = cand - NrHosts;
               if (!win_found && host_req_i[cand]) begin
                  win_found = 1'b1;
                  win_idx   = idx_t'(cand);
               end
            end
         end
      end
   end

   assign handshake = win_found && dev_gnt_i;
   assign stall     = win_found && !dev_gnt_i;
   assign push      = handshake;
   assign pop       = dev_rvalid_i && !fifo_empty;

   always_comb begin
      dev_req_o     = win_found;
      dev_addr_o    = '0;
      dev_we_o      = 1'b0;
      dev_be_o      = '0;
      dev_wdata_o   = '0;
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      if (win_found) begin
         dev_addr_o          = host_addr_i[win_idx];
         dev_we_o            = host_we_i[win_idx];
         dev_be_o            = host_be_i[win_idx];
         dev_wdata_o         = host_wdata_i[win_idx];
         host_gnt_o[win_idx] = dev_gnt_i;
      end
      if (pop) begin
         host_rvalid_o[head] = 1'b1;
         host_err_o[head]    = dev_err_i;
      end
   end

   always_comb begin
      for (int i = 0; i < NrHosts; i++) host_rdata_o[i] = dev_rdata_i;
   end

   assign unexp_rsp_o = unexp_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         unexp_q    <= 1'b0;
      end else begin
         // A lock only survives as a stall; a dropped locked request clears it.
         if (handshake) begin
            rr_ptr_q <= idx_inc(win_idx);
            lock_q   <= 1'b0;
         end else if (stall) begin
            lock_q     <= 1'b1;
            lock_idx_q <= win_idx;
         end else begin
            lock_q <= 1'b0;
         end
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
         if (dev_rvalid_i && fifo_empty) unexp_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= win_idx;
   end

endmodule
